// File: rtl/avl_pkt_arbiter.sv
// avl_pkt_arbiter: packet-granular round-robin arbiter sharing one NoC-to-Avalon flit path among NUM_REQ requesters.
// Ports: clk, rst (async active-low); req_data_in/req_valid_in/req_sop_in/req_eop_in per-requester slices,
// req_ready_out per requester; noc_data_out/noc_valid_out/noc_sop_out/noc_eop_out muxed path, noc_ready_in;
// grant_idx current/last owner, busy while a packet is locked, err_orphan sticky orphan-beat flag.
// Optional macro AVL_PKT_ARBITER_STATS_EN adds pkt_count (16-bit EOP counter per requester).
module avl_pkt_arbiter #(
    parameter int AVL_DATA_WIDTH = 512,
    parameter int WIDTH_PKT      = AVL_DATA_WIDTH + 1 + 1 + 32,
    parameter int NUM_REQ        = 4,
    parameter int RR_W           = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*WIDTH_PKT-1:0] req_data_in,
    input  logic [NUM_REQ*4-1:0]         req_valid_in,
    input  logic [NUM_REQ*4-1:0]         req_sop_in,
    input  logic [NUM_REQ*4-1:0]         req_eop_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    output logic [WIDTH_PKT-1:0]         noc_data_out,
    output logic [3:0]                   noc_valid_out,
    output logic [3:0]                   noc_sop_out,
    output logic [3:0]                   noc_eop_out,
    input  logic                         noc_ready_in,
    output logic [RR_W-1:0]              grant_idx,
    output logic                         busy,
    output logic                         err_orphan
`ifdef AVL_PKT_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]        pkt_count
`endif
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state, state_nx;
    logic [RR_W-1:0]    owner, owner_nx, rr_ptr, rr_nx, winner, sel;
    logic [NUM_REQ-1:0] has_beat, elig;
    logic               found, sel_en, sel_eop, xfer, orphan;

    function automatic logic [RR_W-1:0] nxt(input logic [RR_W-1:0] x);
        nxt = (int'(x) == NUM_REQ - 1) ? '0 : x + RR_W'(1);
    endfunction

    always_comb begin
        has_beat = '0;
        elig     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            has_beat[i] = |req_valid_in[i*4 +: 4];
            elig[i]     = |(req_sop_in[i*4 +: 4] & req_valid_in[i*4 +: 4]);
        end
    end

    // Scan downward so the index closest to rr_ptr is the last to write winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found  = rst;
                winner = RR_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Reset clears state asynchronously and gates found, so every output drops to zero at once.
    assign sel           = (state == LOCKED) ? owner : winner;
    assign sel_en        = (state == LOCKED) || found;
    assign noc_valid_out = sel_en ? req_valid_in[int'(sel)*4 +: 4] : '0;
    assign noc_sop_out   = sel_en ? req_sop_in[int'(sel)*4 +: 4] : '0;
    assign noc_eop_out   = sel_en ? req_eop_in[int'(sel)*4 +: 4] : '0;
    assign noc_data_out  = sel_en ? req_data_in[int'(sel)*WIDTH_PKT +: WIDTH_PKT] : '0;
    assign req_ready_out = sel_en ? (NUM_REQ'(noc_ready_in) << sel) : '0;
    assign sel_eop       = |(noc_eop_out & noc_valid_out);
    assign xfer          = noc_ready_in && |noc_valid_out;
    assign orphan        = (state == IDLE) && |(has_beat & ~elig);
    assign grant_idx     = (state == IDLE && found) ? winner : owner;
    assign busy          = (state == LOCKED);

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_nx    = rr_ptr;
        if (xfer && state == IDLE) begin
            owner_nx = winner;
            state_nx = sel_eop ? IDLE : LOCKED;
            rr_nx    = sel_eop ? nxt(winner) : rr_ptr;
        end else if (xfer && sel_eop) begin
            state_nx = IDLE;
            rr_nx    = nxt(owner);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            err_orphan <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            rr_ptr     <= rr_nx;
            err_orphan <= err_orphan | orphan;
        end
    end

`ifdef AVL_PKT_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (xfer && sel_eop && int'(sel) == i)
                    pkt_count[i*16 +: 16] <= pkt_count[i*16 +: 16] + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_avl_pkt_arbiter.sv
// tb_avl_pkt_arbiter: directed self-checking bench for avl_pkt_arbiter (NUM_REQ=4).
module tb_avl_pkt_arbiter;
    localparam int W = 546;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N*W-1:0] req_data_in = '0;
    logic [N*4-1:0] req_valid_in = '0, req_sop_in = '0, req_eop_in = '0;
    logic [N-1:0]   req_ready_out;
    logic [W-1:0]   noc_data_out;
    logic [3:0]     noc_valid_out, noc_sop_out, noc_eop_out;
    logic           noc_ready_in = 1'b0;
    logic [1:0]     grant_idx;
    logic           busy, err_orphan;
`ifdef AVL_PKT_ARBITER_STATS_EN
    logic [N*16-1:0] pkt_count;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    avl_pkt_arbiter dut (
        .clk(clk), .rst(rst),
        .req_data_in(req_data_in), .req_valid_in(req_valid_in),
        .req_sop_in(req_sop_in), .req_eop_in(req_eop_in),
        .req_ready_out(req_ready_out),
        .noc_data_out(noc_data_out), .noc_valid_out(noc_valid_out),
        .noc_sop_out(noc_sop_out), .noc_eop_out(noc_eop_out),
        .noc_ready_in(noc_ready_in),
        .grant_idx(grant_idx), .busy(busy), .err_orphan(err_orphan)
`ifdef AVL_PKT_ARBITER_STATS_EN
        , .pkt_count(pkt_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] v, input logic [3:0] s,
                           input logic [3:0] e, input logic [15:0] d);
        req_valid_in[i*4 +: 4] = v;
        req_sop_in[i*4 +: 4]   = s;
        req_eop_in[i*4 +: 4]   = e;
        req_data_in[i*W +: W]  = W'(d);
    endtask

    task automatic clear_all();
        req_valid_in = '0;
        req_sop_in   = '0;
        req_eop_in   = '0;
        req_data_in  = '0;
    endtask

    task automatic do_reset();
        clear_all();
        noc_ready_in = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_req(0, 4'hF, 4'h1, 4'h8, 16'h1234);
        noc_ready_in = 1'b1;
        #3;
        total++; if (noc_valid_out !== 4'h0) begin bad++; $display("FAIL rst_valid got=%h exp=0", noc_valid_out); end
        total++; if (req_ready_out !== 4'h0) begin bad++; $display("FAIL rst_ready got=%b exp=0000", req_ready_out); end
        total++; if (busy !== 1'b0 || grant_idx !== 2'd0 || err_orphan !== 1'b0)
            begin bad++; $display("FAIL rst_status got busy=%b grant=%0d err=%b exp 0/0/0", busy, grant_idx, err_orphan); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        noc_ready_in = 1'b1;
        set_req(0, 4'hF, 4'h1, 4'h0, 16'hA000);
        #1;
        total++; if (noc_valid_out !== 4'hF || noc_sop_out !== 4'h1 || noc_data_out !== W'(16'hA000))
            begin bad++; $display("FAIL single_b1 got v=%h s=%h d=%h exp F/1/a000", noc_valid_out, noc_sop_out, noc_data_out[15:0]); end
        total++; if (req_ready_out !== 4'b0001 || grant_idx !== 2'd0)
            begin bad++; $display("FAIL single_b1_rdy got=%b g=%0d exp 0001/0", req_ready_out, grant_idx); end
        tick();
        set_req(0, 4'hF, 4'h0, 4'h0, 16'hA001);
        #1;
        total++; if (busy !== 1'b1 || noc_data_out !== W'(16'hA001) || req_ready_out !== 4'b0001)
            begin bad++; $display("FAIL single_b2 got busy=%b d=%h r=%b exp 1/a001/0001", busy, noc_data_out[15:0], req_ready_out); end
        tick();
        set_req(0, 4'hF, 4'h0, 4'h8, 16'hA002);
        #1;
        total++; if (noc_eop_out !== 4'h8 || noc_data_out !== W'(16'hA002))
            begin bad++; $display("FAIL single_b3 got e=%h d=%h exp 8/a002", noc_eop_out, noc_data_out[15:0]); end
        tick();
        set_req(0, 4'h1, 4'h1, 4'h1, 16'hB000);
        set_req(1, 4'h1, 4'h1, 4'h1, 16'hB001);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got busy=%b exp 0", busy); end
        total++; if (grant_idx !== 2'd1 || req_ready_out !== 4'b0010)
            begin bad++; $display("FAIL single_rrptr got g=%0d r=%b exp 1/0010", grant_idx, req_ready_out); end
        tick();
        total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL single_wrap got g=%0d exp 0", grant_idx); end
        clear_all();
    endtask

    task automatic test_round_robin();
        do_reset();
        noc_ready_in = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 4'h1, 4'h1, 4'h1, 16'(16'hC000 + i));
        #1;
        for (int c = 0; c < 8; c++) begin
            total++; if (grant_idx !== 2'(c % 4) || req_ready_out !== 4'(1 << (c % 4)) || noc_data_out !== W'(16'hC000 + c % 4))
                begin bad++; $display("FAIL rr_cycle%0d got g=%0d r=%b d=%h exp %0d", c, grant_idx, req_ready_out, noc_data_out[15:0], c % 4); end
            tick();
        end
        clear_all();
    endtask

    task automatic test_lock();
        do_reset();
        noc_ready_in = 1'b1;
        set_req(2, 4'hF, 4'h1, 4'h0, 16'hD200);
        tick();
        set_req(2, 4'hF, 4'h0, 4'h0, 16'hD201);
        set_req(0, 4'h1, 4'h1, 4'h1, 16'hD000);
        set_req(3, 4'h1, 4'h1, 4'h1, 16'hD300);
        #1;
        total++; if (req_ready_out !== 4'b0100 || grant_idx !== 2'd2 || busy !== 1'b1)
            begin bad++; $display("FAIL lock_mid got r=%b g=%0d busy=%b exp 0100/2/1", req_ready_out, grant_idx, busy); end
        tick();
        set_req(2, 4'h0, 4'h0, 4'h0, 16'h0);
        #1;
        total++; if (noc_valid_out !== 4'h0 || busy !== 1'b1 || req_ready_out !== 4'b0100)
            begin bad++; $display("FAIL lock_bubble got v=%h busy=%b r=%b exp 0/1/0100", noc_valid_out, busy, req_ready_out); end
        tick();
        set_req(2, 4'hF, 4'h0, 4'h2, 16'hD202);
        #1;
        total++; if (req_ready_out !== 4'b0100 || noc_data_out !== W'(16'hD202))
            begin bad++; $display("FAIL lock_eop got r=%b d=%h exp 0100/d202", req_ready_out, noc_data_out[15:0]); end
        tick();
        set_req(2, 4'h0, 4'h0, 4'h0, 16'h0);
        #1;
        total++; if (grant_idx !== 2'd3 || req_ready_out !== 4'b1000 || busy !== 1'b0)
            begin bad++; $display("FAIL lock_next3 got g=%0d r=%b busy=%b exp 3/1000/0", grant_idx, req_ready_out, busy); end
        tick();
        total++; if (grant_idx !== 2'd0 || req_ready_out !== 4'b0001)
            begin bad++; $display("FAIL lock_next0 got g=%0d r=%b exp 0/0001", grant_idx, req_ready_out); end
        clear_all();
    endtask

    task automatic test_backpressure();
        do_reset();
        noc_ready_in = 1'b0;
        set_req(1, 4'h3, 4'h1, 4'h0, 16'hE100);
        set_req(3, 4'h3, 4'h1, 4'h0, 16'hE300);
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (grant_idx !== 2'd1 || req_ready_out !== 4'b0000 || busy !== 1'b0 || noc_valid_out !== 4'h3 || noc_data_out !== W'(16'hE100))
                begin bad++; $display("FAIL bp_stall%0d got g=%0d r=%b busy=%b v=%h", c, grant_idx, req_ready_out, busy, noc_valid_out); end
            tick();
        end
        noc_ready_in = 1'b1;
        #1;
        total++; if (req_ready_out !== 4'b0010) begin bad++; $display("FAIL bp_release got r=%b exp 0010", req_ready_out); end
        tick();
        set_req(1, 4'h1, 4'h0, 4'h1, 16'hE101);
        #1;
        total++; if (busy !== 1'b1 || grant_idx !== 2'd1)
            begin bad++; $display("FAIL bp_locked got busy=%b g=%0d exp 1/1", busy, grant_idx); end
        tick();
        set_req(1, 4'h0, 4'h0, 4'h0, 16'h0);
        #1;
        total++; if (grant_idx !== 2'd3 || busy !== 1'b0)
            begin bad++; $display("FAIL bp_after got g=%0d busy=%b exp 3/0", grant_idx, busy); end
        clear_all();
    endtask

    task automatic test_orphan_reset();
        do_reset();
        noc_ready_in = 1'b1;
        set_req(1, 4'h1, 4'h0, 4'h0, 16'hF100);
        #1;
        total++; if (noc_valid_out !== 4'h0 || req_ready_out !== 4'b0000)
            begin bad++; $display("FAIL orphan_stall got v=%h r=%b exp 0/0000", noc_valid_out, req_ready_out); end
        tick();
        total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_flag got=%b exp 1", err_orphan); end
        clear_all();
        set_req(0, 4'h1, 4'h1, 4'h1, 16'hF000);
        tick();
        clear_all();
        set_req(2, 4'hF, 4'h1, 4'h0, 16'hF200);
        tick();
        set_req(2, 4'hF, 4'h0, 4'h0, 16'hF201);
        #1;
        total++; if (busy !== 1'b1 || err_orphan !== 1'b1)
            begin bad++; $display("FAIL orphan_prelock got busy=%b err=%b exp 1/1", busy, err_orphan); end
        #1;
        rst = 1'b0;
        #1;
        total++; if (noc_valid_out !== 4'h0 || noc_data_out !== '0 || req_ready_out !== 4'b0000 || busy !== 1'b0 || grant_idx !== 2'd0 || err_orphan !== 1'b0)
            begin bad++; $display("FAIL async_rst got v=%h r=%b busy=%b g=%0d err=%b", noc_valid_out, req_ready_out, busy, grant_idx, err_orphan); end
        clear_all();
        tick();
        rst = 1'b1;
        set_req(0, 4'h1, 4'h1, 4'h1, 16'hF001);
        set_req(1, 4'h1, 4'h1, 4'h1, 16'hF101);
        #1;
        total++; if (grant_idx !== 2'd0 || req_ready_out !== 4'b0001)
            begin bad++; $display("FAIL rst_rrptr got g=%0d r=%b exp 0/0001", grant_idx, req_ready_out); end
        clear_all();
    endtask

`ifdef AVL_PKT_ARBITER_STATS_EN
    task automatic test_stats();
        do_reset();
        noc_ready_in = 1'b1;
        set_req(0, 4'h1, 4'h1, 4'h1, 16'h5000);
        for (int c = 0; c < 65537; c++) tick();
        clear_all();
        #1;
        total++; if (pkt_count !== 64'h0000_0000_0000_0001)
            begin bad++; $display("FAIL stats_count got=%h exp 0000000000000001", pkt_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_orphan_reset();
`ifdef AVL_PKT_ARBITER_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
